// File: rtl/y_pkg.sv
// Shared definitions for the y_dmux_1to4 demultiplexer.
//   NLANES     : number of output lanes
//   SEL_W      : width of a lane index / select
//   lane_idx_t : lane index type (also the round-robin pointer type)
package y_pkg;

  localparam int NLANES = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] lane_idx_t;

  localparam lane_idx_t LANE_STEP = lane_idx_t'(1);

endpackage

// File: rtl/y_lane_reg.sv
// One output lane: a single-entry holding register with a valid flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data this edge (takes priority over drain)
//   load_data  : word to capture
//   drain      : consumer takes the held word this cycle
//   data       : held word (kept after drain, meaningless while valid=0)
//   valid      : lane holds a word
module y_lane_reg #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SIZE-1:0] load_data,
  input  logic            drain,
  output logic [SIZE-1:0] data,
  output logic            valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // A refill on the same edge as a drain leaves the lane full.
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/y_dmux_1to4.sv
// Registered 1-to-4 demultiplexer with per-lane valid/ready handshakes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/valid/ready : producer side; in_ready is combinational
//   sel                 : explicit target lane when rr_en=0
//   rr_en               : target the round-robin pointer instead of sel
//   out_data0..3        : lane holding registers
//   out_valid/out_ready : per-lane handshake, bit k = lane k
//   rr_ptr              : round-robin pointer
//   xfer_cnt            : wrapping count of accepted input words
module y_dmux_1to4
  import y_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SIZE-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic             rr_en,
  output logic [SIZE-1:0]  out_data0,
  output logic [SIZE-1:0]  out_data1,
  output logic [SIZE-1:0]  out_data2,
  output logic [SIZE-1:0]  out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       rr_ptr,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1);

  lane_idx_t       target;
  logic            accept;
  logic [SIZE-1:0] lane_data [NLANES];

  assign target = rr_en ? rr_ptr : sel;

  // Only the target lane gates the producer; a lane that drains this
  // cycle can be refilled this cycle.
  assign in_ready = rst_n & (~out_valid[target] | out_ready[target]);
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    y_lane_reg #(.SIZE(SIZE)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept && (target == lane_idx_t'(k))),
      .load_data (in_data),
      .drain     (out_ready[k]),
      .data      (lane_data[k]),
      .valid     (out_valid[k])
    );
  end

  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];
  assign out_data3 = lane_data[3];

  // The pointer stalls on a blocked lane rather than skipping it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      xfer_cnt <= '0;
    end else if (accept) begin
      xfer_cnt <= xfer_cnt + CNT_STEP;
      if (rr_en) begin
        rr_ptr <= rr_ptr + LANE_STEP;
      end
    end
  end

endmodule

// File: tb/tb_y_dmux_1to4.sv
module tb_y_dmux_1to4;

  localparam int SIZE  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [SIZE-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sel;
  logic             rr_en;
  logic [SIZE-1:0]  out_data0, out_data1, out_data2, out_data3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] xfer_cnt;

  int n_pass  = 0;
  int n_total = 0;

  y_dmux_1to4 #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .rr_en     (rr_en),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what each lane holds, which lanes are full, the
  // round-robin position and how many words have been taken.
  logic [SIZE-1:0] m_data  [4];
  bit              m_valid [4];
  int              m_ptr;
  int              m_cnt;

  function automatic int model_target();
    return rr_en ? m_ptr : int'(sel);
  endfunction

  function automatic bit model_ready();
    int t;
    t = model_target();
    return (!m_valid[t]) || out_ready[t];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_data[k]  = '0;
        m_valid[k] = 1'b0;
      end
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      int  t;
      bit  acc;
      t   = model_target();
      acc = in_valid && model_ready();
      for (int k = 0; k < 4; k++)
        if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
      if (acc) begin
        m_data[t]  = in_data;
        m_valid[t] = 1'b1;
        m_cnt      = (m_cnt + 1) % (1 << CNT_W);
        if (rr_en) m_ptr = (m_ptr + 1) % 4;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [SIZE-1:0] dut_lane(input int k);
    case (k)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic [3:0] ev;
      for (int k = 0; k < 4; k++) ev[k] = m_valid[k];
      check("in_ready", 64'(in_ready), 64'(model_ready()));
      check("out_valid", 64'(out_valid), 64'(ev));
      check("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
      check("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
      for (int k = 0; k < 4; k++)
        if (m_valid[k]) check($sformatf("out_data%0d", k), 64'(dut_lane(k)), 64'(m_data[k]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [SIZE-1:0] d, input logic [1:0] s, input logic rr);
    in_valid = 1'b1;
    in_data  = d;
    sel      = s;
    rr_en    = rr;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    sel       = 2'd0;
    rr_en     = 1'b0;
    out_ready = 4'b0000;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_reset_valid", 64'(out_valid), 64'd0);

    // Explicit select, all consumers ready.
    out_ready = 4'b1111;
    offer(32'hAAAA0000, 2'd0, 1'b0); step();
    offer(32'hBBBB0001, 2'd1, 1'b0); step();
    offer(32'hCCCC0002, 2'd2, 1'b0); step();
    offer(32'hDDDD0003, 2'd3, 1'b0); step();
    in_valid = 1'b0;
    check("sel_lane0", 64'(out_data0), 64'hAAAA0000);
    check("sel_lane1", 64'(out_data1), 64'hBBBB0001);
    check("sel_lane2", 64'(out_data2), 64'hCCCC0002);
    check("sel_lane3", 64'(out_data3), 64'hDDDD0003);
    check("sel_valid", 64'(out_valid), 64'b1000);
    check("sel_cnt", 64'(xfer_cnt), 64'd4);
    check("sel_ptr", 64'(rr_ptr), 64'd0);
    step();

    // Backpressure on lane 2.
    out_ready = 4'b0000;
    offer(32'h12345678, 2'd2, 1'b0); step();
    in_data = 32'h9ABCDEF0;
    check("bp_blocked", 64'(in_ready), 64'd0);
    step();
    check("bp_hold_data", 64'(out_data2), 64'h12345678);
    check("bp_still_blocked", 64'(in_ready), 64'd0);
    out_ready = 4'b0100;
    #1;
    check("bp_refill_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_new_data", 64'(out_data2), 64'h9ABCDEF0);
    check("bp_new_valid", 64'(out_valid[2]), 64'd1);
    check("bp_cnt", 64'(xfer_cnt), 64'd6);
    out_ready = 4'b1111;
    step();

    // Round-robin, back-to-back.
    for (int i = 1; i <= 6; i++) begin
      offer(SIZE'(i), 2'd3, 1'b1);
      step();
    end
    in_valid = 1'b0;
    check("rr_ptr_end", 64'(rr_ptr), 64'd2);
    check("rr_lane0", 64'(out_data0), 64'd5);
    check("rr_lane1", 64'(out_data1), 64'd6);
    check("rr_lane2", 64'(out_data2), 64'd3);
    check("rr_lane3", 64'(out_data3), 64'd4);
    check("rr_cnt", 64'(xfer_cnt), 64'd12);
    step();

    // Round-robin stall on full lane 1.
    out_ready = 4'b1101;
    offer(32'h55, 2'd1, 1'b0); step();
    offer(32'hA2, 2'd0, 1'b1); step();
    offer(32'hA3, 2'd0, 1'b1); step();
    offer(32'hA0, 2'd0, 1'b1); step();
    offer(32'hA1, 2'd0, 1'b1);
    check("stall_cnt_wrap", 64'(xfer_cnt), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", 64'(in_ready), 64'd0);
      check("stall_ptr", 64'(rr_ptr), 64'd1);
      step();
    end
    check("stall_lane1", 64'(out_data1), 64'h55);
    check("stall_lane0", 64'(out_data0), 64'hA0);
    check("stall_lane2", 64'(out_data2), 64'hA2);
    check("stall_lane3", 64'(out_data3), 64'hA3);
    out_ready = 4'b1111;
    #1;
    check("stall_release", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("stall_ptr_adv", 64'(rr_ptr), 64'd2);
    check("stall_lane1_new", 64'(out_data1), 64'hA1);

    // Asynchronous reset with lanes full.
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      offer(32'hF00 + SIZE'(i), 2'd0, 1'b1);
      step();
    end
    in_valid = 1'b0;
    check("prefill_valid", 64'(out_valid), 64'hF);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_ptr", 64'(rr_ptr), 64'd0);
    check("async_cnt", 64'(xfer_cnt), 64'd0);
    check("async_ready", 64'(in_ready), 64'd0);
    check("async_data0", 64'(out_data0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Counter wrap: 17 accepts with a 4-bit counter.
    out_ready = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      offer(SIZE'($urandom), 2'($urandom_range(0, 3)), 1'b0);
      step();
    end
    in_valid = 1'b0;
    check("cnt_wrap", 64'(xfer_cnt), 64'd1);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = SIZE'($urandom);
      sel       = 2'($urandom_range(0, 3));
      rr_en     = ($urandom_range(0, 1) == 1);
      out_ready = 4'($urandom_range(0, 15));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/y_dmux_1to4.md
Name: y_dmux_1to4

Overview:
Registered 1-to-4 demultiplexer, the distributing counterpart of the 4-to-1 selector used in the datapath. One SIZE-bit input stream is steered to one of four output lanes. Each lane has a one-entry holding register and a valid/ready handshake. The lane is chosen either by an explicit 2-bit select or by an internal round-robin pointer. It feeds four downstream consumers, such as register-bank write ports or per-unit operand queues, from a single producer.

Parameters:
SIZE, 32, data width of the input word and of each output lane.
CNT_W, 16, width of the accepted-transfer counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_data  in  SIZE  word offered by the producer.
in_valid  in  1  producer has a word on in_data.
in_ready  out  1  block accepts in_data this cycle (combinational).
sel  in  2  explicit target lane; used when rr_en=0.
rr_en  in  1  1 = target is the round-robin pointer; 0 = target is sel.
out_data0..out_data3  out  SIZE each  lane holding registers.
out_valid  out  4  bit k = lane k holds a word.
out_ready  in  4  bit k = consumer k takes out_data k this cycle.
rr_ptr  out  2  current round-robin pointer.
xfer_cnt  out  CNT_W  count of accepted input words.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=4'b0000, out_data0..3=0, rr_ptr=0, xfer_cnt=0. in_ready reads 0 while rst_n is low.
- Deassertion of rst_n is synchronised externally; the first accept can occur on the first rising edge after release.
- Target lane t = rr_en ? rr_ptr : sel (combinational).
- in_ready = rst_n & (!out_valid[t] | out_ready[t]).
  - An occupied lane that drains in the same cycle can be refilled in that cycle.
  - in_ready must not depend on in_valid.
- Accept = in_valid & in_ready. On the accepting edge:
  - out_data_t <= in_data and out_valid[t] <= 1.
  - xfer_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - If rr_en=1, rr_ptr <= rr_ptr+1, wrapping 3 -> 0.
- Latency: a word accepted at edge N is visible on lane t from edge N through at least edge N+1 (one cycle, registered). There is no combinational path from in_data to out_data.
- Lane drain: on an edge where out_valid[k] & out_ready[k] and lane k is not being refilled, out_valid[k] <= 0. out_data_k keeps its last value; consumers must ignore it while valid=0.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data_k and out_valid[k] hold.
- Lanes are independent. Draining a non-target lane never affects in_ready.
- rr_ptr advances only on an accept with rr_en=1. It is frozen while rr_en=0 and when the target lane is blocked. Round-robin therefore stalls on a full lane; it does not skip it.
- Switching rr_en or sel mid-stream takes effect on the same cycle's target computation. No state is flushed.
- Simultaneous events:
  - Refill and drain of the same lane on one edge: lane ends valid with the new word.
  - Drains on several lanes plus an accept on another lane: all apply on the same edge.
- Reset mid-operation discards all held words. Consumers see out_valid drop asynchronously.

Decomposition:
- Shared package (y_pkg): lane-count constant NLANES=4, select width SEL_W=2, lane-index type.
- One sub-module, y_lane_reg, instantiated 4 times:
  - contents: one SIZE-bit holding register with valid flag, load/drain handshake, async active-low reset.
  - top-level scope: target decode, in_ready mux, rr_ptr and xfer_cnt logic.

Test Plan:
1. Reset check: assert rst_n=0 mid-cycle with lanes full -> out_valid=0000, rr_ptr=0, xfer_cnt=0 immediately, before the next clk edge.
2. Explicit select: rr_en=0, all out_ready=1. Send 0xAAAA0000 sel=0, 0xBBBB0001 sel=1, 0xCCCC0002 sel=2, 0xDDDD0003 sel=3 on consecutive cycles -> each appears on its lane one cycle later, xfer_cnt=4, rr_ptr stays 0.
3. Backpressure: out_ready=0000, sel=2. Send 0x12345678, then 0x9ABCDEF0 -> first accepted; in_ready=0 for the second while sel=2; out_data2 holds 0x12345678. Raise out_ready[2] -> second accepted that same cycle, out_data2=0x9ABCDEF0 next edge.
4. Round-robin: rr_en=1, out_ready=1111, 6 back-to-back words 1..6 -> lanes 0,1,2,3,0,1 receive 1,2,3,4,5,6; rr_ptr ends at 2, xfer_cnt=6.
5. Round-robin stall: rr_en=1, rr_ptr=1, lane 1 full with out_ready[1]=0 -> in_ready=0 and rr_ptr stays 1 for 5 cycles, lanes 0/2/3 untouched. Release out_ready[1] -> accept, rr_ptr=2.
6. Counter wrap: CNT_W=4, 17 accepts -> xfer_cnt=1. Randomized 500-iteration run against a reference model of per-lane words -> zero mismatches.
